mem_access_ctrl: RTL and testbench

//  Host-side sequencer directly upstream of the 8x8-bit memory module. Accepts

---
 rtl/mem_access_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Host-side sequencer for the 8x8-bit memory: queues read/write requests and drives the pins with setup/access timing.
// Read data valid ACCESS_CYC+3 cycles after an idle push; o_req_ready = !full, o_rsp_valid/o_rsp_rdata held until taken.

module mac_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push_vld,
   output logic         o_push_rdy,
   input  logic [W-1:0] i_push_dat,
   input  logic         i_pop,
   output logic [W-1:0] o_head_dat,
   output logic         o_empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   logic [W-1:0]   mem_q [DEPTH];
   logic [W-1:0]   mem_d [DEPTH];
   logic           full;
   logic           push;
   logic           pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign o_empty    = (wr_ptr_q == rd_ptr_q);
   assign o_push_rdy = !full;
   assign push       = i_push_vld && !full;
   assign pop        = i_pop && !o_empty;
   assign o_head_dat = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q[PTR_W-1:0]] = i_push_dat;
         wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end
endmodule

module mem_access_ctrl #(
   parameter int ADDR_W     = 3,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 2,
   parameter int ACCESS_CYC = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_op,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic [ADDR_W-1:0] o_mem_adr,
   output logic [DATA_W-1:0] o_mem_din,
   output logic              o_mem_op,
   output logic              o_mem_select,
   input  logic [DATA_W-1:0] i_mem_dout,
   output logic              o_busy
);
   localparam int CNT_W = $clog2(ACCESS_CYC + 1);

   typedef struct packed {
      logic              op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   req_t              push_dat;
   req_t              head_dat;
   logic              fifo_empty;
   logic              fifo_pop;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              op_q, op_d;
   logic              sel_q, sel_d;
   logic              rsp_vld_q, rsp_vld_d;
   logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;

   assign push_dat = '{op: i_req_op, addr: i_req_addr, wdata: i_req_wdata};

   mac_fifo #(
      .W     ($bits(req_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_req_fifo (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_push_vld (i_req_valid),
      .o_push_rdy (o_req_ready),
      .i_push_dat (push_dat),
      .i_pop      (fifo_pop),
      .o_head_dat (head_dat),
      .o_empty    (fifo_empty)
   );

   // The pin registers double as the command register, so SETUP already presents a stable address.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      adr_d     = adr_q;
      din_d     = din_q;
      op_d      = op_q;
      sel_d     = sel_q;
      rsp_vld_d = rsp_vld_q;
      rsp_dat_d = rsp_dat_q;
      fifo_pop  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               adr_d    = head_dat.addr;
               din_d    = head_dat.wdata;
               op_d     = head_dat.op;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            sel_d   = 1'b1;
            cnt_d   = CNT_W'(ACCESS_CYC);
            state_d = ACCESS;
         end
         ACCESS: begin
            if (cnt_q == CNT_W'(1)) begin
               sel_d = 1'b0;
               if (op_q) begin
                  state_d = IDLE;
               end else begin
                  rsp_dat_d = i_mem_dout;
                  state_d   = RESP;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            // Valid is raised one cycle into RESP and only dropped by an actual transfer.
            if (!rsp_vld_q) begin
               rsp_vld_d = 1'b1;
            end else if (i_rsp_ready) begin
               rsp_vld_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         adr_q     <= '0;
         din_q     <= '0;
         op_q      <= 1'b0;
         sel_q     <= 1'b0;
         rsp_vld_q <= 1'b0;
         rsp_dat_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         adr_q     <= adr_d;
         din_q     <= din_d;
         op_q      <= op_d;
         sel_q     <= sel_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_dat_q <= rsp_dat_d;
      end
   end

   assign o_mem_adr    = adr_q;
   assign o_mem_din    = din_q;
   assign o_mem_op     = op_q;
   assign o_mem_select = sel_q;
   assign o_rsp_valid  = rsp_vld_q;
   assign o_rsp_rdata  = rsp_dat_q;
   assign o_busy       = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 8x8 memory on the pin side.
// Responses, select pulse widths and request stalls are collected on the falling edge.

module tb_mem_access_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_op = 1'b0;
   logic [2:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_rdata;
   logic [2:0] mem_adr;
   logic [7:0] mem_din;
   logic       mem_op;
   logic       mem_select;
   logic [7:0] mem_dout;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] mem_m [8];
   int         sel_run = 0;
   int         sel_runs[$];
   logic [7:0] rsp_q[$];
   int         stall_cnt = 0;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_op     (req_op),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_rdata  (rsp_rdata),
      .o_mem_adr    (mem_adr),
      .o_mem_din    (mem_din),
      .o_mem_op     (mem_op),
      .o_mem_select (mem_select),
      .i_mem_dout   (mem_dout),
      .o_busy       (busy)
   );

   assign mem_dout = mem_m[mem_adr];

   always @(negedge clk) begin
      if (mem_select && mem_op) mem_m[mem_adr] = mem_din;
      if (mem_select) sel_run++;
      else if (sel_run > 0) begin
         sel_runs.push_back(sel_run);
         sel_run = 0;
      end
      if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_rdata);
      if (req_valid && !req_ready) stall_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic op, input logic [2:0] addr, input logic [7:0] wdata);
      int n = 0;
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("push_timeout", 32'(req_ready), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 300);
      if (busy) chk({tag, "_timeout"}, 32'(busy), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rsp(input string tag, input logic [7:0] exp);
      if (rsp_q.size() == 0) chk(tag, 32'hFFFF_FFFF, 32'(exp));
      else chk(tag, 32'(rsp_q.pop_front()), 32'(exp));
   endtask

   task automatic check_runs(input string tag, input int n_exp);
      int bad = 0;
      foreach (sel_runs[i]) if (sel_runs[i] != 2) bad++;
      chk({tag, "_sel_count"}, 32'(sel_runs.size()), 32'(n_exp));
      chk({tag, "_sel_width"}, 32'(bad), 0);
      sel_runs.delete();
   endtask

   task automatic wait_rsp_valid(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 50);
      chk(tag, 32'(rsp_valid), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   lat;
      logic ok_v, ok_d, sel_seen, rsp_seen;

      for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
      #1 rst_n = 1'b0;
      #20;
      chk("rst_req_ready", 32'(req_ready), 1);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
      chk("rst_mem_select", 32'(mem_select), 0);
      chk("rst_mem_adr", 32'(mem_adr), 0);
      chk("rst_mem_din", 32'(mem_din), 0);
      chk("rst_mem_op", 32'(mem_op), 0);
      chk("rst_busy", 32'(busy), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: single write then read, latency and select width
      push(1'b1, 3'd3, 8'hA5);
      req_valid = 1'b0;
      wait_idle("t1_w");
      chk("t1_mem3", 32'(mem_m[3]), 32'hA5);
      push(1'b0, 3'd3, 8'h00);
      req_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) begin
            lat = k;
            break;
         end
      end
      chk("t1_latency", 32'(lat), 5);
      wait_idle("t1_r");
      expect_rsp("t1_rdata", 8'hA5);
      check_runs("t1", 2);

      // 2: back-to-back writes fill the FIFO, then read all back in order
      stall_cnt = 0;
      for (int i = 0; i < 8; i++) push(1'b1, 3'(i), 8'(1 << i));
      req_valid = 1'b0;
      chk("t2_ready_dropped", 32'(stall_cnt > 0), 1);
      wait_idle("t2_w");
      for (int i = 0; i < 8; i++) chk($sformatf("t2_mem%0d", i), 32'(mem_m[i]), 32'(1 << i));
      for (int i = 0; i < 8; i++) push(1'b0, 3'(i), 8'h00);
      req_valid = 1'b0;
      wait_idle("t2_r");
      for (int i = 0; i < 8; i++) expect_rsp($sformatf("t2_rd%0d", i), 8'(1 << i));
      check_runs("t2", 16);

      // 3: held response stays stable and blocks the queued write
      rsp_ready = 1'b0;
      push(1'b0, 3'd5, 8'h00);
      push(1'b1, 3'd1, 8'h77);
      req_valid = 1'b0;
      wait_rsp_valid("t3_rsp_valid");
      ok_v = 1'b1;
      ok_d = 1'b1;
      sel_seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (!rsp_valid) ok_v = 1'b0;
         if (rsp_rdata !== 8'h20) ok_d = 1'b0;
         if (mem_select) sel_seen = 1'b1;
      end
      chk("t3_valid_stable", 32'(ok_v), 1);
      chk("t3_rdata_stable", 32'(ok_d), 1);
      chk("t3_no_next_access", 32'(sel_seen), 0);
      chk("t3_mem1_untouched", 32'(mem_m[1]), 32'h02);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      wait_idle("t3");
      expect_rsp("t3_rdata", 8'h20);
      chk("t3_mem1_written", 32'(mem_m[1]), 32'h77);
      check_runs("t3", 2);

      // 4: read-after-write in one burst
      push(1'b1, 3'd2, 8'h3C);
      push(1'b0, 3'd2, 8'h00);
      req_valid = 1'b0;
      wait_idle("t4");
      expect_rsp("t4_raw", 8'h3C);
      check_runs("t4", 2);

      // 5: reset during ACCESS of a write
      push(1'b1, 3'd6, 8'h99);
      push(1'b0, 3'd7, 8'h00);
      req_valid = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
         if (mem_select) break;
      end
      chk("t5_in_access", 32'(mem_select), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_sel_dropped", 32'(mem_select), 0);
      chk("t5_req_ready", 32'(req_ready), 1);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_rsp_valid", 32'(rsp_valid), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rsp_seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid || mem_select) rsp_seen = 1'b1;
      end
      chk("t5_no_activity", 32'(rsp_seen), 0);
      chk("t5_mem6_kept", 32'(mem_m[6]), 32'h40);
      chk("t5_no_rsp", 32'(rsp_q.size()), 0);
      sel_runs.delete();
      @(posedge clk);
      #1;

      // 6: FIFO full, pop and push in the same cycle
      rsp_ready = 1'b0;
      push(1'b0, 3'd4, 8'h00);
      push(1'b1, 3'd4, 8'h55);
      push(1'b0, 3'd4, 8'h00);
      req_valid = 1'b0;
      wait_rsp_valid("t6_rsp_valid");
      chk("t6_full", 32'(req_ready), 0);
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_op    = 1'b0;
      req_addr  = 3'd0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("t6_c0_ready", 32'(req_ready), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t6_pop_cycle_ready", 32'(req_ready), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t6_after_pop_ready", 32'(req_ready), 1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_idle("t6");
      expect_rsp("t6_rd_a", 8'h10);
      expect_rsp("t6_rd_b", 8'h55);
      expect_rsp("t6_rd_c", 8'h01);
      check_runs("t6", 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
